// File: rtl/pf_queue_pkg.sv
// Shared fetch-side entry layout: {insn, pc, illegal} packed MSB to LSB.
package pf_queue_pkg;

    localparam int unsigned PF_INSN_W  = 32;
    localparam int unsigned PF_ILL_OFS = 0;
    localparam int unsigned PF_PC_OFS  = 1;

    function automatic int unsigned pf_insn_ofs(input int unsigned aw);
        return PF_PC_OFS + aw;
    endfunction

    function automatic int unsigned pf_entry_w(input int unsigned aw);
        return PF_INSN_W + aw + 1;
    endfunction

    localparam int unsigned PF_DEFAULT_AW = 32;
    localparam int unsigned PF_ENTRY_W    = pf_entry_w(PF_DEFAULT_AW);

endpackage

// File: rtl/pf_queue_mem.sv
// Register-file RAM for queue entries: one synchronous write port, one asynchronous read port.
module pf_queue_mem
    import pf_queue_pkg::*;
#(
    parameter int unsigned LGDEPTH = 2,
    parameter int unsigned WIDTH   = PF_ENTRY_W
) (
    input  logic               clk,
    input  logic               we,
    input  logic [LGDEPTH-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [LGDEPTH-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] ram [2**LGDEPTH];

    always_ff @(posedge clk) begin
        if (we)
            ram[waddr] <= wdata;
    end

    assign rdata = ram[raddr];

endmodule

// File: rtl/pf_queue.sv
// Prefetch-to-decode instruction queue; a stored bus error poisons further fetches until flush.
module pf_queue
    import pf_queue_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned LGDEPTH       = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_new_pc,
    input  logic                     i_clear_cache,
    input  logic [31:0]              i_pf_i,
    input  logic [ADDRESS_WIDTH-1:0] i_pf_pc,
    input  logic                     i_pf_valid,
    input  logic                     i_pf_illegal,
    output logic                     o_pf_stalled_n,
    output logic [31:0]              o_i,
    output logic [ADDRESS_WIDTH-1:0] o_pc,
    output logic                     o_valid,
    output logic                     o_illegal,
    input  logic                     i_stalled_n,
    output logic [LGDEPTH:0]         o_fill
);

    localparam int unsigned AW       = ADDRESS_WIDTH;
    localparam int unsigned EW       = pf_entry_w(AW);
    localparam int unsigned INSN_OFS = pf_insn_ofs(AW);
    localparam logic [LGDEPTH:0] FULL = {1'b1, {LGDEPTH{1'b0}}};

    logic [LGDEPTH:0] wr_ptr, rd_ptr, count, count_next;
    logic             poison, poison_next, stalled_n_next;
    logic             flush, en, de;
    logic [EW-1:0]    wr_entry, head;

    assign flush    = i_rst | i_new_pc | i_clear_cache;
    assign en       = (i_pf_valid | i_pf_illegal) & o_pf_stalled_n & ~flush & ~poison;
    assign de       = (o_valid | o_illegal) & i_stalled_n & ~flush;
    // illegal bit comes straight from the bus error, so it wins over valid
    assign wr_entry = {i_pf_i, i_pf_pc, i_pf_illegal};

    always_comb begin
        count_next  = count;
        poison_next = poison;
        if (flush) begin
            count_next  = '0;
            poison_next = 1'b0;
        end else begin
            case ({en, de})
                2'b10:   count_next = count + 1'b1;
                2'b01:   count_next = count - 1'b1;
                default: count_next = count;
            endcase
            if (en && i_pf_illegal)
                poison_next = 1'b1;
        end
        stalled_n_next = (count_next != FULL) & ~poison_next;
    end

    always_ff @(posedge i_clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (en)
                wr_ptr <= wr_ptr + 1'b1;
            if (de)
                rd_ptr <= rd_ptr + 1'b1;
        end
        count          <= count_next;
        poison         <= poison_next;
        o_pf_stalled_n <= stalled_n_next;
    end

    pf_queue_mem #(
        .LGDEPTH (LGDEPTH),
        .WIDTH   (EW)
    ) u_mem (
        .clk   (i_clk),
        .we    (en),
        .waddr (wr_ptr[LGDEPTH-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[LGDEPTH-1:0]),
        .rdata (head)
    );

    // head view depends only on registered state (pointer, count, RAM)
    assign o_i       = head[INSN_OFS +: 32];
    assign o_pc      = head[PF_PC_OFS +: AW];
    assign o_valid   = (count != '0) & ~head[PF_ILL_OFS];
    assign o_illegal = (count != '0) &  head[PF_ILL_OFS];
    assign o_fill    = count;

endmodule

// File: tb/tb_pf_queue.sv
// Scoreboard bench for pf_queue: stimulus pushes expected entries, a negedge monitor pops on each dequeue.
module tb_pf_queue;

    localparam int unsigned AW  = 32;
    localparam int unsigned LGD = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        ill;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          new_pc = 1'b0;
    logic          clr = 1'b0;
    logic          pf_valid = 1'b0;
    logic          pf_illegal = 1'b0;
    logic          stalled_n = 1'b0;
    logic [31:0]   pf_i = '0;
    logic [AW-1:0] pf_pc = '0;
    logic          pf_stalled_n, ovalid, oillegal;
    logic [31:0]   oi;
    logic [AW-1:0] opc;
    logic [LGD:0]  fill;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pf_queue #(
        .ADDRESS_WIDTH (AW),
        .LGDEPTH       (LGD)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_new_pc       (new_pc),
        .i_clear_cache  (clr),
        .i_pf_i         (pf_i),
        .i_pf_pc        (pf_pc),
        .i_pf_valid     (pf_valid),
        .i_pf_illegal   (pf_illegal),
        .o_pf_stalled_n (pf_stalled_n),
        .o_i            (oi),
        .o_pc           (opc),
        .o_valid        (ovalid),
        .o_illegal      (oillegal),
        .i_stalled_n    (stalled_n),
        .o_fill         (fill)
    );

    function automatic logic [31:0] insn_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic ill);
        exp_t e;
        e.pc   = pc;
        e.insn = insn_of(pc);
        e.ill  = ill;
        exp_q.push_back(e);
    endtask

    // holds a word on the prefetch port until taken; n = edges waited, -1 on timeout
    task automatic send(input logic [31:0] pc, input logic ill, input int max, output int n);
        logic acc;
        pf_pc      = pc;
        pf_i       = insn_of(pc);
        pf_valid   = 1'b1;
        pf_illegal = ill;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < max) begin
            @(negedge clk);
            acc = pf_stalled_n && !(rst || new_pc || clr);
            @(posedge clk);
            #1;
            n++;
        end
        pf_valid   = 1'b0;
        pf_illegal = 1'b0;
        if (!acc)
            n = -1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if ((ovalid === 1'b1 || oillegal === 1'b1) && stalled_n && !(rst || new_pc || clr)) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: got pc=%0h ill=%0b want none", opc, oillegal);
                end else begin
                    e = exp_q.pop_front();
                    if ({opc, oi, oillegal, ovalid} !== {e.pc, e.insn, e.ill, ~e.ill}) begin
                        bad++;
                        $display("FAIL head_out: got pc=%0h i=%0h ill=%0b v=%0b want pc=%0h i=%0h ill=%0b v=%0b",
                                 opc, oi, oillegal, ovalid, e.pc, e.insn, e.ill, ~e.ill);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;

        // reset, then idle
        tick;
        tick;
        rst = 1'b0;
        check("rst_valid",   64'(ovalid),       64'd0);
        check("rst_illegal", 64'(oillegal),     64'd0);
        check("rst_fill",    64'(fill),         64'd0);
        check("rst_stall_n", 64'(pf_stalled_n), 64'd1);
        repeat (10) tick;
        check("idle_valid",   64'(ovalid),       64'd0);
        check("idle_fill",    64'(fill),         64'd0);
        check("idle_stall_n", 64'(pf_stalled_n), 64'd1);

        // fill with decode stalled
        stalled_n = 1'b0;
        for (int i = 0; i < 6; i++)
            expect_out(32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            send(32'h100 + 32'(i), 1'b0, 4, n);
            check("fill_accept", 64'(n), 64'd1);
        end
        check("full_fill",    64'(fill),         64'd4);
        check("full_stall_n", 64'(pf_stalled_n), 64'd0);
        pf_pc    = 32'h104;
        pf_i     = insn_of(32'h104);
        pf_valid = 1'b1;
        repeat (2) tick;
        check("held_fill",    64'(fill),         64'd4);
        check("held_stall_n", 64'(pf_stalled_n), 64'd0);
        stalled_n = 1'b1;
        send(32'h104, 1'b0, 4, n);
        check("held_accept_lat", 64'(n), 64'd2);
        send(32'h105, 1'b0, 4, n);
        check("after_full_accept", 64'(n), 64'd1);
        repeat (8) tick;
        check("drain_fill",  64'(fill),         64'd0);
        check("drain_queue", 64'(exp_q.size()), 64'd0);

        // streaming with decode always ready
        for (int i = 0; i < 8; i++)
            expect_out(32'h110 + 32'(i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(32'h110 + 32'(i), 1'b0, 4, n);
            check("stream_accept", 64'(n),      64'd1);
            check("stream_fill",   64'(fill),   64'd1);
            check("stream_pc",     64'(opc),    64'h110 + 64'(i));
            check("stream_valid",  64'(ovalid), 64'd1);
        end
        repeat (3) tick;
        check("stream_end_fill",  64'(fill),         64'd0);
        check("stream_end_queue", 64'(exp_q.size()), 64'd0);

        // flush mid-stream: 0x200..0x203 must never reach decode
        stalled_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'h200 + 32'(i), 1'b0, 4, n);
            check("flush_pre_accept", 64'(n), 64'd1);
        end
        check("flush_pre_fill", 64'(fill), 64'd3);
        pf_pc    = 32'h203;
        pf_i     = insn_of(32'h203);
        pf_valid = 1'b1;
        new_pc   = 1'b1;
        tick;
        new_pc   = 1'b0;
        pf_valid = 1'b0;
        check("flush_fill",    64'(fill),         64'd0);
        check("flush_valid",   64'(ovalid),       64'd0);
        check("flush_stall_n", 64'(pf_stalled_n), 64'd1);
        expect_out(32'h400, 1'b0);
        send(32'h400, 1'b0, 4, n);
        check("post_flush_accept", 64'(n),      64'd1);
        check("post_flush_pc",     64'(opc),    64'h400);
        check("post_flush_valid",  64'(ovalid), 64'd1);
        stalled_n = 1'b1;
        tick;
        tick;
        check("post_flush_drain", 64'(fill), 64'd0);

        // bus error poisons the stream until cache clear
        stalled_n = 1'b0;
        expect_out(32'h300, 1'b0);
        expect_out(32'h301, 1'b1);
        send(32'h300, 1'b0, 4, n);
        check("berr_accept0", 64'(n), 64'd1);
        send(32'h301, 1'b1, 4, n);
        check("berr_accept1",   64'(n),            64'd1);
        check("berr_stall_n",   64'(pf_stalled_n), 64'd0);
        check("berr_fill",      64'(fill),         64'd2);
        check("berr_head_ill",  64'(oillegal),     64'd0);
        pf_pc    = 32'h302;
        pf_i     = insn_of(32'h302);
        pf_valid = 1'b1;
        repeat (3) tick;
        check("poison_fill",    64'(fill),         64'd2);
        check("poison_stall_n", 64'(pf_stalled_n), 64'd0);
        stalled_n = 1'b1;
        tick;
        check("illegal_head_ill",   64'(oillegal), 64'd1);
        check("illegal_head_valid", 64'(ovalid),   64'd0);
        check("illegal_head_pc",    64'(opc),      64'h301);
        tick;
        repeat (2) tick;
        check("poison_drain_fill",    64'(fill),         64'd0);
        check("poison_drain_stall_n", 64'(pf_stalled_n), 64'd0);
        clr = 1'b1;
        tick;
        clr      = 1'b0;
        pf_valid = 1'b0;
        check("clear_stall_n", 64'(pf_stalled_n), 64'd1);
        check("clear_fill",    64'(fill),         64'd0);

        // reset with three entries and poison set
        stalled_n = 1'b0;
        send(32'h600, 1'b0, 4, n);
        check("rst2_accept0", 64'(n), 64'd1);
        send(32'h601, 1'b0, 4, n);
        check("rst2_accept1", 64'(n), 64'd1);
        send(32'h602, 1'b1, 4, n);
        check("rst2_accept2", 64'(n),            64'd1);
        check("rst2_fill",    64'(fill),         64'd3);
        check("rst2_stall_n", 64'(pf_stalled_n), 64'd0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst2_valid_after",   64'(ovalid),       64'd0);
        check("rst2_illegal_after", 64'(oillegal),     64'd0);
        check("rst2_fill_after",    64'(fill),         64'd0);
        check("rst2_stall_after",   64'(pf_stalled_n), 64'd1);
        expect_out(32'h500, 1'b0);
        send(32'h500, 1'b0, 4, n);
        check("post_rst_accept", 64'(n),      64'd1);
        check("post_rst_valid",  64'(ovalid), 64'd1);
        check("post_rst_pc",     64'(opc),    64'h500);
        stalled_n = 1'b1;
        tick;
        stalled_n = 1'b0;
        repeat (2) tick;
        check("final_fill",  64'(fill),         64'd0);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
